// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I types and constants for the ID/EX operand stage
//
// Purpose: ALU operation encodings (identical to the ALU's own), alu_op control
// encodings from the main decoder, and the packed ID/EX pipeline register.
// Ports: none (package).
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLTI = 4'b1100;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [1:0] ALUOP_UPPER  = 2'b11;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] operation;
  } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - bus between the ID/MEM/WB stages and the ID/EX operand stage
//
// Purpose: bundles every non-clock signal of id_ex_operand_stage.
// master: the surrounding pipeline (drives id_*, flush, mem_*, wb_*).
// slave:  the operand stage (drives stall, ex_*, SrcA, SrcB, Operation).
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     id_valid;
  logic [4:0]               id_rs1;
  logic [4:0]               id_rs2;
  logic [4:0]               id_rd;
  logic [DATA_WIDTH-1:0]    id_rd1;
  logic [DATA_WIDTH-1:0]    id_rd2;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic                     id_alu_src;
  logic [1:0]               id_alu_op;
  logic [2:0]               id_funct3;
  logic                     id_funct7b5;
  logic                     id_is_rtype;
  logic                     id_mem_read;
  logic                     id_mem_write;
  logic                     id_reg_write;
  logic                     flush;
  logic [4:0]               mem_rd;
  logic                     mem_reg_write;
  logic [DATA_WIDTH-1:0]    mem_result;
  logic [4:0]               wb_rd;
  logic                     wb_reg_write;
  logic [DATA_WIDTH-1:0]    wb_result;
  logic                     stall;
  logic                     ex_valid;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic                     ex_mem_write;
  logic [4:0]               ex_rd;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ex_store_data;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_alu_src,
           id_alu_op, id_funct3, id_funct7b5, id_is_rtype, id_mem_read,
           id_mem_write, id_reg_write, flush, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
           SrcA, SrcB, Operation, ex_store_data
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm, id_alu_src,
           id_alu_op, id_funct3, id_funct7b5, id_is_rtype, id_mem_read,
           id_mem_write, id_reg_write, flush, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    output stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd,
           SrcA, SrcB, Operation, ex_store_data
  );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational ALU control decode
//
// Purpose: maps main-decoder alu_op plus funct3/funct7[5]/R-type flag to the
// 4-bit ALU operation code.
// Ports: alu_op[1:0], funct3[2:0], funct7b5, is_rtype in; operation[3:0] out.
module alu_op_decode
  import rv32i_pkg::*;
(
  input  logic [1:0]          alu_op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                is_rtype,
  output logic [ALU_OP_W-1:0] operation
);

  always_comb begin
    operation = ALU_ADD;
    case (alu_op)
      ALUOP_MEM, ALUOP_UPPER: operation = ALU_ADD;
      // beq/bne compare equality; blt/bge/bltu/bgeu (funct3[2]=1) use less-than.
      ALUOP_BRANCH: operation = funct3[2] ? ALU_SLTI : ALU_EQ;
      ALUOP_ARITH: begin
        case (funct3)
          3'b000:         operation = (is_rtype & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:         operation = ALU_SLL;
          3'b010, 3'b011: operation = ALU_SLTI;
          3'b100:         operation = ALU_XOR;
          // srai carries funct7[5] in its immediate, so no is_rtype gating here.
          3'b101:         operation = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:         operation = ALU_OR;
          default:        operation = ALU_AND;
        endcase
      end
      default: operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register and ALU operand front end
//
// Purpose: registers decoded ID fields, produces the ALU operation code, and
// resolves RAW hazards by forwarding (EX/MEM over MEM/WB) plus load-use stall.
// Optional feature macro: ID_EX_FORWARDING_EN. When undefined, no forwarding
// muxes exist and stall is raised on any pending writer of a source register.
// Ports: clk, reset (synchronous, active-high), bus (id_ex_operand_stage_if.slave).
module id_ex_operand_stage
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  id_ex_operand_stage_if.slave bus
);

  id_ex_t                   ex_q;
  id_ex_t                   id_pkt;
  logic [OPCODE_LENGTH-1:0] id_operation;
  logic [DATA_WIDTH-1:0]    fwd_a;
  logic [DATA_WIDTH-1:0]    fwd_b;
  logic                     stall;

  alu_op_decode u_alu_op_decode (
    .alu_op    (bus.id_alu_op),
    .funct3    (bus.id_funct3),
    .funct7b5  (bus.id_funct7b5),
    .is_rtype  (bus.id_is_rtype),
    .operation (id_operation)
  );

  // id_valid=0 still loads its fields; only ex_valid marks it as not real.
  always_comb begin
    id_pkt           = '0;
    id_pkt.valid     = bus.id_valid;
    id_pkt.reg_write = bus.id_reg_write;
    id_pkt.mem_read  = bus.id_mem_read;
    id_pkt.mem_write = bus.id_mem_write;
    id_pkt.alu_src   = bus.id_alu_src;
    id_pkt.rd        = bus.id_rd;
    id_pkt.rs1       = bus.id_rs1;
    id_pkt.rs2       = bus.id_rs2;
    id_pkt.rd1       = bus.id_rd1;
    id_pkt.rd2       = bus.id_rd2;
    id_pkt.imm       = bus.id_imm;
    id_pkt.operation = id_operation;
  end

`ifdef ID_EX_FORWARDING_EN
  // x0 is excluded by the rd!=0 tests, so a bubble (rs=0) never forwards.
  function automatic logic [DATA_WIDTH-1:0] forward(
    input logic [4:0]            rs,
    input logic [DATA_WIDTH-1:0] reg_data,
    input logic [4:0]            m_rd,
    input logic                  m_we,
    input logic [DATA_WIDTH-1:0] m_data,
    input logic [4:0]            w_rd,
    input logic                  w_we,
    input logic [DATA_WIDTH-1:0] w_data
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
      return m_data;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
      return w_data;
    end
    return reg_data;
  endfunction

  always_comb begin
    fwd_a = forward(ex_q.rs1, ex_q.rd1, bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                    bus.wb_rd, bus.wb_reg_write, bus.wb_result);
    fwd_b = forward(ex_q.rs2, ex_q.rd2, bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                    bus.wb_rd, bus.wb_reg_write, bus.wb_result);
  end

  // Only a load in EX cannot be forwarded in time; everything else forwards.
  always_comb begin
    stall = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
            ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2)) & ~bus.flush;
  end
`else
  function automatic logic writer_hit(
    input logic [4:0] rs,
    input id_ex_t     ex,
    input logic [4:0] m_rd,
    input logic       m_we,
    input logic [4:0] w_rd,
    input logic       w_we
  );
    return (rs != 5'd0) &&
           ((ex.valid && ex.reg_write && (ex.rd == rs)) ||
            (m_we && (m_rd == rs)) ||
            (w_we && (w_rd == rs)));
  endfunction

  // Without forwarding, wait until the producer has left WB (register file
  // then returns the fresh value).
  always_comb begin
    stall = bus.id_valid & ~bus.flush &
            (writer_hit(bus.id_rs1, ex_q, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write) |
             writer_hit(bus.id_rs2, ex_q, bus.mem_rd, bus.mem_reg_write, bus.wb_rd, bus.wb_reg_write));
  end

  always_comb begin
    fwd_a = ex_q.rd1;
    fwd_b = ex_q.rd2;
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_q.rs1, ex_q.rs2, bus.mem_result, bus.wb_result};
`endif

  // reset > flush > stall; all three load the all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_pkt;
    end
  end

  assign bus.stall         = stall;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.SrcA          = fwd_a;
  assign bus.SrcB          = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign bus.ex_store_data = fwd_b;
  assign bus.Operation     = ex_q.operation;

endmodule
